// File: rtl/channel_4_noise_voice.sv
// Channel 4 noise voice: phase accumulator carries clock a 15-bit LFSR whose
// low bit picks the sign of the envelope; the result is a registered signed sample.
module channel_4_noise_voice #(
    parameter int unsigned OUT_WIDTH = 16,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sample_stb,
    input  logic                 i_enable,
    input  logic                 i_retrigger,
    input  logic                 i_short_mode,
    input  logic [31:0]          i_phase_delta,
    input  logic [8:0]           i_envelope,
    output logic [OUT_WIDTH-1:0] o_sample,
    output logic                 o_sample_valid
);

    logic [31:0]          r_phase_acc;
    logic [14:0]          r_lfsr;
    logic [8:0]           r_env;
    logic                 r_pend;

    logic                 accept;
    logic [32:0]          acc_sum;
    logic                 fb;
    logic [14:0]          lfsr_next;
    logic [OUT_WIDTH-1:0] env_ext;
    logic [OUT_WIDTH-1:0] sample_next;

    always_comb begin
        accept      = i_sample_stb & i_enable & ~i_retrigger;
        acc_sum     = {1'b0, r_phase_acc} + {1'b0, i_phase_delta};
        fb          = i_short_mode ? (r_lfsr[0] ^ r_lfsr[6]) : (r_lfsr[0] ^ r_lfsr[1]);
        lfsr_next   = {fb, r_lfsr[14:1]};
        // Zero envelope negates to zero, so no negative zero is possible.
        env_ext     = {{(OUT_WIDTH-9){1'b0}}, r_env};
        sample_next = r_lfsr[0] ? -env_ext : env_ext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase_acc    <= '0;
            r_lfsr         <= LFSR_SEED;
            r_env          <= '0;
            r_pend         <= 1'b0;
            o_sample       <= '0;
            o_sample_valid <= 1'b0;
        end else begin
            if (i_retrigger) begin
                r_phase_acc <= '0;
                r_lfsr      <= LFSR_SEED;
            end else if (accept) begin
                r_phase_acc <= acc_sum[31:0];
                if (acc_sum[32]) begin
                    r_lfsr <= lfsr_next;
                end
            end
            if (accept) begin
                r_env <= i_envelope;
            end
            // A strobe accepted last edge completes even if enable or retrigger changed since.
            r_pend         <= accept;
            o_sample_valid <= r_pend;
            if (r_pend) begin
                o_sample <= sample_next;
            end
        end
    end

endmodule

// File: tb/tb_channel_4_noise_voice.sv
// Directed bench for channel_4_noise_voice with a small accumulator/LFSR model.
module tb_channel_4_noise_voice;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        en;
    logic        retrig;
    logic        short_m;
    logic [31:0] delta;
    logic [8:0]  env;
    logic [15:0] sample;
    logic        valid;

    int n_checks;
    int n_fail;

    logic [31:0] m_acc;
    logic [14:0] m_lfsr;

    channel_4_noise_voice #(
        .OUT_WIDTH(16),
        .LFSR_SEED(15'h0001)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sample_stb  (stb),
        .i_enable      (en),
        .i_retrigger   (retrig),
        .i_short_mode  (short_m),
        .i_phase_delta (delta),
        .i_envelope    (env),
        .o_sample      (sample),
        .o_sample_valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        logic [32:0] s;
        logic        f;
        s = {1'b0, m_acc} + {1'b0, delta};
        m_acc = s[31:0];
        if (s[32]) begin
            f = short_m ? (m_lfsr[0] ^ m_lfsr[6]) : (m_lfsr[0] ^ m_lfsr[1]);
            m_lfsr = {f, m_lfsr[14:1]};
        end
    endtask

    function automatic logic [15:0] exp_sample();
        logic [15:0] e;
        e = {7'b0, env};
        return m_lfsr[0] ? -e : e;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_acc  = '0;
        m_lfsr = 15'h0001;
    endtask

    // One strobe spaced over 4 cycles; reports valid before, at and after the expected pulse.
    task automatic strobe(output logic [15:0] s, output logic v_mid, output logic v_out,
                          output logic v_after);
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        if (en && !retrig) model_step();
        v_mid = valid;
        @(negedge clk);
        v_out = valid;
        s = sample;
        @(negedge clk);
        v_after = valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (sample !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sample got %h want 0000", sample);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", valid);
        end
        n_checks++;
        if (dut.r_lfsr !== 15'h0001) begin
            n_fail++; $display("FAIL reset_lfsr got %h want 0001", dut.r_lfsr);
        end
        n_checks++;
        if (dut.r_phase_acc !== 32'h0) begin
            n_fail++; $display("FAIL reset_acc got %h want 0", dut.r_phase_acc);
        end
    endtask

    task automatic test_half_delta();
        logic [15:0] s;
        logic vm, vo, va;
        apply_reset();
        delta = 32'h8000_0000; env = 9'd11; short_m = 1'b0;
        strobe(s, vm, vo, va);
        n_checks++;
        if (vm !== 1'b0 || vo !== 1'b1 || va !== 1'b0) begin
            n_fail++; $display("FAIL half_s1_timing got %b%b%b want 010", vm, vo, va);
        end
        n_checks++;
        // Seed bit0 is 1, so the first sample is negative.
        if (s !== 16'hFFF5) begin
            n_fail++; $display("FAIL half_s1_sample got %h want fff5", s);
        end
        strobe(s, vm, vo, va);
        n_checks++;
        if (dut.r_lfsr !== 15'h4000) begin
            n_fail++; $display("FAIL half_s2_lfsr got %h want 4000", dut.r_lfsr);
        end
        n_checks++;
        if (s !== 16'h000B || vo !== 1'b1) begin
            n_fail++; $display("FAIL half_s2_sample got %h/%b want 000b/1", s, vo);
        end
    endtask

    task automatic test_full_delta();
        logic [15:0] s;
        logic vm, vo, va;
        logic [14:0] want [3];
        want[0] = 15'h4000; want[1] = 15'h2000; want[2] = 15'h1000;
        apply_reset();
        delta = 32'hFFFF_FFFF; env = 9'd100; short_m = 1'b0;
        strobe(s, vm, vo, va);
        n_checks++;
        if (dut.r_lfsr !== 15'h0001) begin
            n_fail++; $display("FAIL full_s1_lfsr got %h want 0001", dut.r_lfsr);
        end
        for (int i = 0; i < 3; i++) begin
            strobe(s, vm, vo, va);
            n_checks++;
            if (dut.r_lfsr !== want[i]) begin
                n_fail++; $display("FAIL full_step%0d_lfsr got %h want %h", i, dut.r_lfsr, want[i]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            env = 9'(i * 13);
            strobe(s, vm, vo, va);
            n_checks++;
            if (dut.r_lfsr !== m_lfsr || s !== exp_sample() || vo !== 1'b1) begin
                n_fail++;
                $display("FAIL long_seq%0d got lfsr %h samp %h v %b want %h %h 1", i,
                         dut.r_lfsr, s, vo, m_lfsr, exp_sample());
            end
        end
        // Short mode from the seed: 93-step period.
        apply_reset();
        short_m = 1'b1; env = 9'd7;
        strobe(s, vm, vo, va);
        for (int i = 1; i <= 93; i++) begin
            strobe(s, vm, vo, va);
            if (i % 10 == 0 || i >= 92) begin
                n_checks++;
                if (dut.r_lfsr !== m_lfsr || s !== exp_sample()) begin
                    n_fail++;
                    $display("FAIL short_seq%0d got lfsr %h samp %h want %h %h", i, dut.r_lfsr,
                             s, m_lfsr, exp_sample());
                end
            end
        end
        n_checks++;
        if (dut.r_lfsr !== 15'h0001) begin
            n_fail++; $display("FAIL short_period got %h want 0001", dut.r_lfsr);
        end
        short_m = 1'b0;
    endtask

    task automatic test_negative();
        logic [15:0] s;
        logic vm, vo, va;
        apply_reset();
        delta = 32'h0; env = 9'd300;
        strobe(s, vm, vo, va);
        n_checks++;
        if (s !== 16'hFED4 || vo !== 1'b1) begin
            n_fail++; $display("FAIL neg300 got %h/%b want fed4/1", s, vo);
        end
        env = 9'd0;
        strobe(s, vm, vo, va);
        n_checks++;
        if (s !== 16'h0000 || vo !== 1'b1) begin
            n_fail++; $display("FAIL env0 got %h/%b want 0000/1", s, vo);
        end
    endtask

    task automatic test_retrigger();
        logic [15:0] s;
        logic [15:0] held;
        logic vm, vo, va;
        apply_reset();
        delta = 32'hFFFF_FFFF; env = 9'd50;
        for (int i = 0; i < 11; i++) strobe(s, vm, vo, va);
        n_checks++;
        if (dut.r_lfsr !== m_lfsr) begin
            n_fail++; $display("FAIL pre_retrig_lfsr got %h want %h", dut.r_lfsr, m_lfsr);
        end
        held = sample;
        @(negedge clk);
        stb = 1'b1; retrig = 1'b1;
        @(negedge clk);
        stb = 1'b0; retrig = 1'b0;
        m_acc = '0; m_lfsr = 15'h0001;
        vm = valid;
        @(negedge clk);
        n_checks++;
        if (vm !== 1'b0 || valid !== 1'b0 || sample !== held) begin
            n_fail++;
            $display("FAIL retrig_drop got v %b%b samp %h want 00 %h", vm, valid, sample, held);
        end
        n_checks++;
        if (dut.r_lfsr !== 15'h0001 || dut.r_phase_acc !== 32'h0) begin
            n_fail++;
            $display("FAIL retrig_state got %h/%h want 0001/0", dut.r_lfsr, dut.r_phase_acc);
        end
        strobe(s, vm, vo, va);
        n_checks++;
        if (dut.r_lfsr !== 15'h0001 || s !== 16'hFFCE) begin
            n_fail++; $display("FAIL retrig_s1 got %h/%h want 0001/ffce", dut.r_lfsr, s);
        end
        strobe(s, vm, vo, va);
        n_checks++;
        if (dut.r_lfsr !== 15'h4000 || s !== 16'h0032) begin
            n_fail++; $display("FAIL retrig_s2 got %h/%h want 4000/0032", dut.r_lfsr, s);
        end
    endtask

    task automatic test_enable();
        logic [15:0] s;
        logic [15:0] held;
        logic [14:0] held_lfsr;
        logic vm, vo, va;
        delta = 32'hFFFF_FFFF; env = 9'd77;
        strobe(s, vm, vo, va);
        held = sample; held_lfsr = dut.r_lfsr;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(s, vm, vo, va);
            n_checks++;
            if (vm !== 1'b0 || vo !== 1'b0 || s !== held || dut.r_lfsr !== held_lfsr) begin
                n_fail++;
                $display("FAIL disabled%0d got v %b%b samp %h lfsr %h want 00 %h %h", i, vm, vo,
                         s, dut.r_lfsr, held, held_lfsr);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(s, vm, vo, va);
            n_checks++;
            if (dut.r_lfsr !== m_lfsr || s !== exp_sample() || vo !== 1'b1) begin
                n_fail++;
                $display("FAIL reenable%0d got %h/%h/%b want %h/%h/1", i, dut.r_lfsr, s, vo,
                         m_lfsr, exp_sample());
            end
        end
        // Enable dropping right after an accepted strobe must not cancel its pulse.
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; en = 1'b0;
        model_step();
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || sample !== exp_sample()) begin
            n_fail++;
            $display("FAIL late_disable got %b/%h want 1/%h", valid, sample, exp_sample());
        end
        en = 1'b1;
        delta = 32'h0;
        for (int i = 0; i < 20; i++) begin
            env = 9'(i * 25 + 1);
            strobe(s, vm, vo, va);
            if (i % 5 == 4) begin
                n_checks++;
                if (s !== exp_sample() || dut.r_lfsr !== m_lfsr) begin
                    n_fail++;
                    $display("FAIL delta0_%0d got %h/%h want %h/%h", i, s, dut.r_lfsr,
                             exp_sample(), m_lfsr);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want [3];
        delta = 32'hFFFF_FFFF; env = 9'd200;
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        model_step(); want[0] = exp_sample();
        @(negedge clk);
        model_step(); want[1] = exp_sample();
        n_checks++;
        if (valid !== 1'b1 || sample !== want[0]) begin
            n_fail++; $display("FAIL b2b_0 got %b/%h want 1/%h", valid, sample, want[0]);
        end
        @(negedge clk);
        stb = 1'b0;
        model_step(); want[2] = exp_sample();
        n_checks++;
        if (valid !== 1'b1 || sample !== want[1]) begin
            n_fail++; $display("FAIL b2b_1 got %b/%h want 1/%h", valid, sample, want[1]);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1 || sample !== want[2]) begin
            n_fail++; $display("FAIL b2b_2 got %b/%h want 1/%h", valid, sample, want[2]);
        end
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got %b want 0", valid);
        end
    endtask

    task automatic test_async_reset();
        delta = 32'hFFFF_FFFF; env = 9'd99;
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (sample !== 16'h0000 || valid !== 1'b0) begin
            n_fail++; $display("FAIL async_rst_out got %h/%b want 0000/0", sample, valid);
        end
        n_checks++;
        if (dut.r_lfsr !== 15'h0001 || dut.r_phase_acc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst_state got %h/%h want 0001/0", dut.r_lfsr, dut.r_phase_acc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; stb = 1'b0; en = 1'b1; retrig = 1'b0; short_m = 1'b0;
        delta = '0; env = '0;
        m_acc = '0; m_lfsr = 15'h0001;
        #12;
        test_reset();
        rst_n = 1'b1;
        test_half_delta();
        test_full_delta();
        test_negative();
        test_retrigger();
        test_enable();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
